// File: rtl/alu16_op_issuer.sv
// Issues one ALU16 operation per request, waits SETTLE_CYCLES, then returns the captured result.
// Optional golden-model self-check of captured results is enabled by defining ALU_SELFCHECK_EN.
module alu16_op_issuer #(
   parameter int SETTLE_CYCLES = 1,
   parameter int CNT_W         = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ReqValid,
   output logic        ReqReady,
   input  logic [15:0] ReqA,
   input  logic [15:0] ReqB,
   input  logic [3:0]  ReqCtrl,
   output logic [15:0] AluA,
   output logic [15:0] AluB,
   output logic [3:0]  AluCtrl,
   input  logic [15:0] AluS,
   input  logic        AluOverflow,
   input  logic        AluZero,
   output logic        RspValid,
   input  logic        RspReady,
   output logic [15:0] RspS,
   output logic        RspOverflow,
   output logic        RspZero,
   output logic        RspErr,
   output logic        RspMismatch,
   output logic [15:0] OpCount
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [15:0]       alu_a_q, alu_a_d;
   logic [15:0]       alu_b_q, alu_b_d;
   logic [3:0]        alu_ctrl_q, alu_ctrl_d;
   logic [15:0]       rsp_s_q, rsp_s_d;
   logic              rsp_ovf_q, rsp_ovf_d;
   logic              rsp_zero_q, rsp_zero_d;
   logic              rsp_err_q, rsp_err_d;
   logic              rsp_mis_q, rsp_mis_d;
   logic [15:0]       op_count_q, op_count_d;
   logic              mis_calc;

`ifdef ALU_SELFCHECK_EN
   function automatic logic [15:0] golden_s(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] op);
      logic [15:0] s;
      case (op)
         4'd0:    s = a & b;
         4'd1:    s = a | b;
         4'd2:    s = a + b;
         4'd3:    s = a - b;
         4'd4:    s = ~a;
         4'd5:    s = ~b;
         4'd6:    s = a + 16'd1;
         4'd7:    s = a - 16'd1;
         default: s = 16'h0000;
      endcase
      return s;
   endfunction

   // Signed overflow: operand signs vs. result sign, plus the INC/DEC wrap points.
   function automatic logic golden_ovf(input logic [15:0] a, input logic [15:0] b,
                                       input logic [3:0] op, input logic [15:0] s);
      logic signed [15:0] sa, sb, ss;
      logic               v;
      sa = $signed(a);
      sb = $signed(b);
      ss = $signed(s);
      case (op)
         4'd2:    v = ((sa < 0) == (sb < 0)) && ((ss < 0) != (sa < 0));
         4'd3:    v = ((sa < 0) != (sb < 0)) && ((ss < 0) != (sa < 0));
         4'd6:    v = (a == 16'h7FFF);
         4'd7:    v = (a == 16'h8000);
         default: v = 1'b0;
      endcase
      return v;
   endfunction

   logic [15:0] gold_s;
   logic        gold_ovf;

   always_comb begin
      gold_s   = golden_s(alu_a_q, alu_b_q, alu_ctrl_q);
      gold_ovf = golden_ovf(alu_a_q, alu_b_q, alu_ctrl_q, gold_s);
   end

   assign mis_calc = (AluS != gold_s) || (AluOverflow != gold_ovf) ||
                     (AluZero != (gold_s == 16'h0000));
`else
   assign mis_calc = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_ctrl_d = alu_ctrl_q;
      rsp_s_d    = rsp_s_q;
      rsp_ovf_d  = rsp_ovf_q;
      rsp_zero_d = rsp_zero_q;
      rsp_err_d  = rsp_err_q;
      rsp_mis_d  = rsp_mis_q;
      op_count_d = op_count_q;
      case (state_q)
         S_IDLE: begin
            if (ReqValid) begin
               if (!ReqCtrl[3]) begin
                  alu_a_d    = ReqA;
                  alu_b_d    = ReqB;
                  alu_ctrl_d = ReqCtrl;
                  cnt_d      = CNT_INIT;
                  state_d    = S_WAIT;
               end else begin
                  // Reserved opcode: answer immediately, ALU bus keeps the last legal op.
                  rsp_s_d    = 16'h0000;
                  rsp_ovf_d  = 1'b0;
                  rsp_zero_d = 1'b0;
                  rsp_err_d  = 1'b1;
                  rsp_mis_d  = 1'b0;
                  state_d    = S_RESP;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               rsp_s_d    = AluS;
               rsp_ovf_d  = AluOverflow;
               rsp_zero_d = AluZero;
               rsp_err_d  = 1'b0;
               rsp_mis_d  = mis_calc;
               state_d    = S_RESP;
            end
         end
         S_RESP: begin
            if (RspReady) begin
               op_count_d = op_count_q + 16'd1;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         alu_a_q    <= 16'h0000;
         alu_b_q    <= 16'h0000;
         alu_ctrl_q <= 4'h0;
         rsp_s_q    <= 16'h0000;
         rsp_ovf_q  <= 1'b0;
         rsp_zero_q <= 1'b0;
         rsp_err_q  <= 1'b0;
         rsp_mis_q  <= 1'b0;
         op_count_q <= 16'h0000;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_ctrl_q <= alu_ctrl_d;
         rsp_s_q    <= rsp_s_d;
         rsp_ovf_q  <= rsp_ovf_d;
         rsp_zero_q <= rsp_zero_d;
         rsp_err_q  <= rsp_err_d;
         rsp_mis_q  <= rsp_mis_d;
         op_count_q <= op_count_d;
      end
   end

   assign ReqReady    = (state_q == S_IDLE);
   assign RspValid    = (state_q == S_RESP);
   assign AluA        = alu_a_q;
   assign AluB        = alu_b_q;
   assign AluCtrl     = alu_ctrl_q;
   assign RspS        = rsp_s_q;
   assign RspOverflow = rsp_ovf_q;
   assign RspZero     = rsp_zero_q;
   assign RspErr      = rsp_err_q;
   assign RspMismatch = rsp_mis_q;
   assign OpCount     = op_count_q;

endmodule
